mcu_core_param: RTL
===================

// Module: mcu_core_param
// PURPOSE
//  Parametrised successor of our fixed-width accumulator microcontroller: program RAM loaded through a port instead of a file,
//  configurable data/PC/register-file sizes, Z/C flags, conditional jumps, IN/OUT handshake ports, halt and single-step debug mode.
//  Sits under the system top; a testbench or boot loader fills program RAM, then pulses start.
// PARAMETERS
//  DATA_W   8   accumulator / register / I/O width (>=4); instruction width INSTR_W = DATA_W+4
//  PC_W     8   program counter width; program RAM depth = 2**PC_W
//  RF_AW    4   register-file address width; 2**RF_AW registers of DATA_W
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst        in   1        synchronous, active-low reset
//  prog_we    in   1        program RAM write strobe, honoured only in LOAD
//  prog_addr  in   PC_W     program RAM write address
//  prog_data  in   INSTR_W  instruction {opcode[3:0], operand[DATA_W-1:0]}
//  start      in   1        1-cycle pulse: begin execution at PC=0 (LOAD or HALT only)
//  step_mode  in   1        1 = pause after every EXECUTE
//  step       in   1        1-cycle pulse: release one instruction while paused
//  in_data    in   DATA_W   input port data
//  in_valid   in   1        input data valid
//  in_ready   out  1        core waiting in IN instruction
//  out_data   out  DATA_W   last value written by OUT (held)
//  out_valid  out  1        1-cycle pulse per OUT
//  pc         out  PC_W     current program counter
//  acc        out  DATA_W   accumulator
//  flag_z     out  1        zero flag
//  flag_c     out  1        carry (ADD/ADDI) / borrow (SUB) flag
//  halted     out  1        state == HALT
// BEHAVIOUR
//  Reset (rst==0 at clk edge): state=LOAD, pc/acc/flags/out_data/out_valid/in_ready/halted=0; register file and program RAM NOT cleared.
//  States: LOAD -> (start) FETCH -> DECODE -> EXECUTE -> FETCH | PAUSE | WAIT_IN | HALT.
//   FETCH: IR <= ram[pc]. DECODE: operand register read, pc <= pc+1 (wraps 2**PC_W-1 -> 0). EXECUTE: commit result.
//   Base latency 3 cycles/instruction; OUT/flags/acc visible the cycle after EXECUTE.
//  Opcodes (operand a = low RF_AW bits, target = low PC_W bits, imm = full operand):
//   0 NOP  1 LDI acc=imm  2 LD acc=RF[a]  3 ST RF[a]=acc  4 ADD  5 SUB  6 AND  7 OR  8 XOR (acc op RF[a])
//   9 ADDI acc+=imm  A JMP  B JZ (if Z)  C JC (if C)  D OUT  E IN  F HLT
//  Flags: Z=(result==0) on LDI/LD/ADD/SUB/AND/OR/XOR/ADDI/IN; C updated only by ADD/ADDI/SUB, else held.
//   Arithmetic modulo 2**DATA_W; C = bit DATA_W of the (DATA_W+1)-bit sum; SUB C=1 when RF[a] > acc (unsigned borrow).
//  Jump taken: pc <= target (overrides increment). Not taken: sequential.
//  OUT: out_data <= acc, out_valid=1 exactly one cycle.
//  IN: EXECUTE -> WAIT_IN, in_ready=1; on in_valid&in_ready acc<=in_data, update Z, in_ready drops, -> FETCH (or PAUSE).
//   in_valid while not in WAIT_IN ignored; core waits indefinitely.
//  HLT: -> HALT, halted=1; start pulse -> FETCH with pc=0, acc/flags/RF preserved.
//  step_mode=1: after EXECUTE (or IN completion) -> PAUSE; step -> FETCH. step_mode cleared while paused -> FETCH next cycle.
//   step outside PAUSE ignored. step_mode has no effect on LOAD/HALT/WAIT_IN.
//  start outside LOAD/HALT ignored. prog_we outside LOAD ignored (program RAM write-protected while running).
//  Simultaneous start & prog_we in LOAD: write completes, execution starts next cycle from pc=0 and sees the new word.
//  Reset mid-instruction: aborts instantly, no partial RF write; program RAM contents retained.
// STRUCTURE
//  mcu_pkg: opcode localparams, state encoding localparams, flag bit indices.
//  mcu_alu (combinational sub-module): opcode, acc, operand -> result[DATA_W-1:0], z, c, wr_acc.
//  Top: FSM, pc/IR/acc/flags, RF array, program RAM array, I/O registers.
// TESTING
//  1 Load {LDI 5, ADDI 3, OUT, HLT}, start -> out_valid once, out_data=8, halted=1, pc=4, 12 cycles start->halted.
//  2 LDI FF, ADDI 01 -> acc=00, Z=1, C=1; LDI 03, ST r2, LDI 01, SUB r2 -> acc=FE, C=1, Z=0.
//  3 Loop LDI 3 / ST r0 / LD r0 / ADDI FF / ST r0 / JZ end / JMP 2 -> body 3 passes, ends at HLT; JC not taken when C=0.
//  4 IN with in_valid low 10 cycles -> in_ready=1 held, pc frozen; in_valid=1 data 5A -> acc=5A next cycle, in_ready=0.
//  5 step_mode=1, 2-instr program -> core in PAUSE after each EXECUTE, advances only on step; prog_we during run has no effect.
//  6 Reset asserted in WAIT_IN -> all outputs 0, state LOAD; start without reload reruns retained program identically.
//  PC wrap: PC_W=3, 8 NOPs no HLT -> pc returns 7 -> 0.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the parametrised accumulator core: opcodes, FSM states, flag indices.
package mcu_pkg;

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OPC_W-1:0] OP_LD   = 4'h2;
  localparam logic [OPC_W-1:0] OP_ST   = 4'h3;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h4;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h5;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h6;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h7;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'h8;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'h9;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'hA;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'hB;
  localparam logic [OPC_W-1:0] OP_JC   = 4'hC;
  localparam logic [OPC_W-1:0] OP_OUT  = 4'hD;
  localparam logic [OPC_W-1:0] OP_IN   = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    S_LOAD, S_FETCH, S_DECODE, S_EXEC, S_PAUSE, S_WAIT_IN, S_HALT
  } state_t;

endpackage

// File: rtl/mcu_core_param_if.sv
// Program-load and IN/OUT handshake bundle between a host (master) and the core (slave).
interface mcu_core_param_if
  import mcu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8
);
  localparam int unsigned INSTR_W = DATA_W + OPC_W;

  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;

  modport master (
    output prog_we, prog_addr, prog_data, in_data, in_valid,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, in_data, in_valid,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mcu_alu.sv
// Combinational ALU: computes the accumulator result and flag updates for the executing opcode.
module mcu_alu
  import mcu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] rf_val,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c,
  output logic              wr_acc
);
  logic [DATA_W:0] sum;

  always_comb begin
    sum    = '0;
    result = acc;
    c      = c_in;
    wr_acc = 1'b0;
    case (opcode)
      OP_LDI:  begin result = imm;    wr_acc = 1'b1; end
      OP_LD:   begin result = rf_val; wr_acc = 1'b1; end
      OP_ADD: begin
        sum = {1'b0, acc} + {1'b0, rf_val};
        result = sum[DATA_W-1:0]; c = sum[DATA_W]; wr_acc = 1'b1;
      end
      // Top bit of the widened difference is the unsigned borrow
      OP_SUB: begin
        sum = {1'b0, acc} - {1'b0, rf_val};
        result = sum[DATA_W-1:0]; c = sum[DATA_W]; wr_acc = 1'b1;
      end
      OP_AND:  begin result = acc & rf_val; wr_acc = 1'b1; end
      OP_OR:   begin result = acc | rf_val; wr_acc = 1'b1; end
      OP_XOR:  begin result = acc ^ rf_val; wr_acc = 1'b1; end
      OP_ADDI: begin
        sum = {1'b0, acc} + {1'b0, imm};
        result = sum[DATA_W-1:0]; c = sum[DATA_W]; wr_acc = 1'b1;
      end
      default: ;
    endcase
    z = (result == '0);
  end
endmodule

// File: rtl/mcu_core_param.sv
// Accumulator microcontroller: port-loaded program RAM, register file, Z/C flags, IN/OUT handshake, halt and single-step.
module mcu_core_param
  import mcu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned RF_AW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  mcu_core_param_if.slave    bus,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  output logic [PC_W-1:0]    pc,
  output logic [DATA_W-1:0]  acc,
  output logic               flag_z,
  output logic               flag_c,
  output logic               halted
);
  localparam int unsigned INSTR_W = DATA_W + OPC_W;
  localparam int unsigned RAM_D   = 2 ** PC_W;
  localparam int unsigned RF_D    = 2 ** RF_AW;

  state_t state, state_nxt;

  logic [INSTR_W-1:0] ram [RAM_D];
  logic [DATA_W-1:0]  rf  [RF_D];
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  rf_q;

  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] operand;
  logic [RF_AW-1:0]  rf_a;
  logic [PC_W-1:0]   target;
  logic              in_hs_c;
  logic              jump_c;
  logic [DATA_W-1:0] alu_res;
  logic              alu_z, alu_c, alu_wr;

  assign opcode  = ir[INSTR_W-1 -: OPC_W];
  assign operand = ir[DATA_W-1:0];
  assign rf_a    = RF_AW'(operand);
  assign target  = PC_W'(operand);
  assign in_hs_c = (state == S_WAIT_IN) && bus.in_valid && bus.in_ready;

  always_comb begin
    case (opcode)
      OP_JMP:  jump_c = 1'b1;
      OP_JZ:   jump_c = flag_z;
      OP_JC:   jump_c = flag_c;
      default: jump_c = 1'b0;
    endcase
  end

  mcu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode (opcode),
    .acc    (acc),
    .imm    (operand),
    .rf_val (rf_q),
    .c_in   (flag_c),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c),
    .wr_acc (alu_wr)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:    if (start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_DECODE;
      S_DECODE:  state_nxt = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_HLT)     state_nxt = S_HALT;
        else if (opcode == OP_IN) state_nxt = S_WAIT_IN;
        else                      state_nxt = step_mode ? S_PAUSE : S_FETCH;
      end
      S_PAUSE:   if (step || !step_mode) state_nxt = S_FETCH;
      S_WAIT_IN: if (in_hs_c) state_nxt = step_mode ? S_PAUSE : S_FETCH;
      S_HALT:    if (start) state_nxt = S_FETCH;
      default:   state_nxt = S_LOAD;
    endcase
  end

  // Architectural registers and I/O; increment in DECODE, jump overrides in EXEC
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc            <= '0;
      acc           <= '0;
      flag_z        <= 1'b0;
      flag_c        <= 1'b0;
      halted        <= 1'b0;
      ir            <= '0;
      rf_q          <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.in_ready  <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      halted        <= (state_nxt == S_HALT);
      case (state)
        S_LOAD, S_HALT: if (start) pc <= '0;
        S_FETCH:  ir <= ram[pc];
        S_DECODE: begin
          rf_q <= rf[rf_a];
          pc   <= pc + PC_W'(1);
        end
        S_EXEC: begin
          if (alu_wr) begin
            acc    <= alu_res;
            flag_z <= alu_z;
          end
          flag_c <= alu_c;
          if (jump_c) pc <= target;
          if (opcode == OP_OUT) begin
            bus.out_data  <= acc;
            bus.out_valid <= 1'b1;
          end
          if (opcode == OP_IN) bus.in_ready <= 1'b1;
        end
        S_WAIT_IN: if (in_hs_c) begin
          acc          <= bus.in_data;
          flag_z       <= (bus.in_data == '0);
          bus.in_ready <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Storage arrays are not reset; writes are blocked while reset is asserted
  always_ff @(posedge clk) begin
    if (rst && state == S_LOAD && bus.prog_we) ram[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst && state == S_EXEC && opcode == OP_ST) rf[rf_a] <= acc;
  end
endmodule
